chopper_phase_ctrl: RTL and testbench

- Per-phase current-chopper sequencer for the microstepper H-bridge driver.
- Walks each PWM cycle through dead-time, leading-edge blanking, on-time and fixed off-time.
- Drives the downstream countdown timer through its start/load/done interface.
- Watches the phase over-current comparator and latches a fault on persistent over-current.

---
 rtl/chopper_phase_ctrl.sv | 166 ++++++++++++++++
 tb/tb_chopper_phase_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/chopper_phase_ctrl.sv
// Per-phase chopper sequencer: dead-time, blanking, on-time and fixed off-time,
// driving an external countdown timer and latching a fault on repeated early trips.
module chopper_phase_ctrl #(
  parameter int TW          = 10,
  parameter int DEAD_CYCLES = 4,
  parameter int FAULT_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          comparator,
  input  logic [TW-1:0] blank_time,
  input  logic [TW-1:0] off_time,
  output logic          timer_start,
  output logic [TW-1:0] timer_load,
  input  logic          timer_done,
  output logic          phase_on,
  output logic          phase_decay,
  output logic          fault,
  output logic [2:0]    state
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int FW = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    BLANK = 3'd2,
    ON    = 3'd3,
    OFF   = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt, fcnt_inc;
  logic          first_on, first_nxt;
  logic          start_nxt;
  logic [TW-1:0] load_nxt, blank_ld, off_ld;
  logic          cmp_q1, cmp_s;

  // Two-flop synchronizer for the asynchronous comparator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_q1 <= 1'b0;
      cmp_s  <= 1'b0;
    end else begin
      cmp_q1 <= comparator;
      cmp_s  <= cmp_q1;
    end
  end

  // A zero interval would never expire the timer, so clamp to one cycle
  assign blank_ld = (blank_time == '0) ? TW'(1) : blank_time;
  assign off_ld   = (off_time   == '0) ? TW'(1) : off_time;
  assign fcnt_inc = fcnt + 1'b1;

  always_comb begin
    nxt       = cur;
    dead_nxt  = dead_cnt;
    fcnt_nxt  = fcnt;
    first_nxt = 1'b0;
    start_nxt = 1'b0;
    load_nxt  = '0;
    case (cur)
      IDLE: begin
        if (enable) begin
          nxt      = DEAD;
          dead_nxt = '0;
        end
      end
      DEAD: begin
        if (!enable) begin
          nxt      = IDLE;
          fcnt_nxt = '0;
        end else if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
          nxt       = BLANK;
          start_nxt = 1'b1;
          load_nxt  = blank_ld;
        end else begin
          dead_nxt = dead_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          nxt      = IDLE;
          fcnt_nxt = '0;
        end else if (timer_done) begin
          nxt       = ON;
          first_nxt = 1'b1;
        end
      end
      ON: begin
        if (!enable) begin
          nxt      = IDLE;
          fcnt_nxt = '0;
        end else if (cmp_s) begin
          // A trip right after blanking means current never regulated normally
          if (first_on) begin
            fcnt_nxt = fcnt_inc;
            if (fcnt_inc >= FW'(FAULT_LIMIT)) begin
              nxt = FAULT;
            end else begin
              nxt       = OFF;
              start_nxt = 1'b1;
              load_nxt  = off_ld;
            end
          end else begin
            fcnt_nxt  = '0;
            nxt       = OFF;
            start_nxt = 1'b1;
            load_nxt  = off_ld;
          end
        end
      end
      OFF: begin
        if (!enable) begin
          nxt      = IDLE;
          fcnt_nxt = '0;
        end else if (timer_done) begin
          nxt      = DEAD;
          dead_nxt = '0;
        end
      end
      FAULT: begin
        if (!enable) begin
          nxt      = IDLE;
          fcnt_nxt = '0;
        end
      end
      default: begin
        nxt      = IDLE;
        fcnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      dead_cnt    <= '0;
      fcnt        <= '0;
      first_on    <= 1'b0;
      timer_start <= 1'b0;
      timer_load  <= '0;
      phase_on    <= 1'b0;
      phase_decay <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur         <= nxt;
      dead_cnt    <= dead_nxt;
      fcnt        <= fcnt_nxt;
      first_on    <= first_nxt;
      timer_start <= start_nxt;
      timer_load  <= load_nxt;
      // Drive outputs decode the state being entered so they line up with it
      phase_on    <= (nxt == BLANK) || (nxt == ON);
      phase_decay <= (nxt == OFF);
      fault       <= (nxt == FAULT);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_chopper_phase_ctrl.sv
// Directed bench for chopper_phase_ctrl: per-cycle vector table plus
// hand-run fault, trip-reset and async-reset sequences.
module tb_chopper_phase_ctrl;

  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, comparator, timer_done;
  logic [TW-1:0] blank_time, off_time;
  logic          timer_start, phase_on, phase_decay, fault;
  logic [TW-1:0] timer_load;
  logic [2:0]    state;

  int pass_cnt = 0;
  int total    = 0;

  chopper_phase_ctrl #(.TW(TW), .DEAD_CYCLES(4), .FAULT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .comparator(comparator),
    .blank_time(blank_time), .off_time(off_time),
    .timer_start(timer_start), .timer_load(timer_load), .timer_done(timer_done),
    .phase_on(phase_on), .phase_decay(phase_decay), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, comp, done;
    logic [TW-1:0] blank, off;
    logic [2:0]    st;
    logic          on, dec, flt, ts;
    logic [TW-1:0] ld;
  } vec_t;

  vec_t tv[36];

  function automatic vec_t mk(input logic en, comp, done, input int blank, off,
                              input int st, input logic on, dec, flt, ts, input int ld);
    vec_t v;
    v.en = en; v.comp = comp; v.done = done;
    v.blank = TW'(blank); v.off = TW'(off);
    v.st = 3'(st); v.on = on; v.dec = dec; v.flt = flt; v.ts = ts; v.ld = TW'(ld);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, state, phase_on, phase_decay, fault, timer_start, timer_load};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {13'd0, v.st, v.on, v.dec, v.flt, v.ts, v.ld};
  endfunction

  task automatic step(input logic en, comp, done);
    enable = en; comparator = comp; timer_done = done;
    @(posedge clk); #1;
  endtask

  // Acts as the timer (done on every BLANK/OFF cycle) and shapes the comparator
  // per ON visit. mode 0: comparator always high. mode 1: visits 1-2 early,
  // visit 3 late, then early again.
  task automatic run_chops(input int mode, output int visits, output int long_v);
    int on_len;
    logic [2:0] st, nst;
    logic comp, done;
    bit ok;
    visits = 0; long_v = 0; on_len = 0; ok = 0;
    st = state;
    for (int i = 0; i < 300; i++) begin
      done = (st == 3'd2) || (st == 3'd4);
      comp = 1'b1;
      if (mode == 1 && visits == 2 && st != 3'd3) comp = 1'b0;
      if (mode == 1 && visits == 3 && st == 3'd3 && on_len < 2) comp = 1'b0;
      step(1'b1, comp, done);
      nst = state;
      if (phase_on && phase_decay) chk("overlap", 32'd1, 32'd0);
      if (nst == 3'd3) begin
        if (st != 3'd3) begin visits++; on_len = 1; end
        else on_len++;
      end else if (st == 3'd3 && on_len > 1) long_v++;
      st = nst;
      if (nst == 3'd5) begin ok = 1; break; end
    end
    if (!ok) chk("fault_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int visits, long_v;
    reset = 1'b1; enable = 0; comparator = 0; timer_done = 0;
    blank_time = 10'd5; off_time = 10'd20;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", outs(), 32'd0);

    // Nominal chop, blanking immunity, zero clamps, ignored dones, drop in OFF
    tv[0]  = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[1]  = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[2]  = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[3]  = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[4]  = mk(1,0,0, 5,20, 2, 1,0,0,1, 5);
    tv[5]  = mk(1,0,0, 9,20, 2, 1,0,0,0, 0);
    tv[6]  = mk(1,0,1, 5,20, 3, 1,0,0,0, 0);
    tv[7]  = mk(1,0,0, 5,20, 3, 1,0,0,0, 0);
    tv[8]  = mk(1,1,0, 5,20, 3, 1,0,0,0, 0);
    tv[9]  = mk(1,1,0, 5,20, 3, 1,0,0,0, 0);
    tv[10] = mk(1,1,0, 5,20, 4, 0,1,0,1, 20);
    tv[11] = mk(1,0,0, 5, 7, 4, 0,1,0,0, 0);
    tv[12] = mk(1,0,1, 5,20, 1, 0,0,0,0, 0);
    tv[13] = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[14] = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[15] = mk(1,0,0, 5,20, 1, 0,0,0,0, 0);
    tv[16] = mk(1,1,0, 0,20, 2, 1,0,0,1, 1);
    tv[17] = mk(1,1,0, 0,20, 2, 1,0,0,0, 0);
    tv[18] = mk(1,0,0, 0,20, 2, 1,0,0,0, 0);
    tv[19] = mk(1,0,1, 0,20, 3, 1,0,0,0, 0);
    tv[20] = mk(1,0,0, 0,20, 3, 1,0,0,0, 0);
    tv[21] = mk(1,0,1, 0,20, 3, 1,0,0,0, 0);
    tv[22] = mk(1,1,0, 0,20, 3, 1,0,0,0, 0);
    tv[23] = mk(1,0,0, 0,20, 3, 1,0,0,0, 0);
    tv[24] = mk(1,0,0, 0, 0, 4, 0,1,0,1, 1);
    tv[25] = mk(1,0,1, 0,20, 1, 0,0,0,0, 0);
    tv[26] = mk(1,0,1, 0,20, 1, 0,0,0,0, 0);
    tv[27] = mk(1,0,0, 0,20, 1, 0,0,0,0, 0);
    tv[28] = mk(1,0,0, 0,20, 1, 0,0,0,0, 0);
    tv[29] = mk(1,0,0, 5,20, 2, 1,0,0,1, 5);
    tv[30] = mk(1,0,1, 5,20, 3, 1,0,0,0, 0);
    tv[31] = mk(1,1,0, 5,20, 3, 1,0,0,0, 0);
    tv[32] = mk(1,0,0, 5,20, 3, 1,0,0,0, 0);
    tv[33] = mk(1,0,0, 5,20, 4, 0,1,0,1, 20);
    tv[34] = mk(0,0,1, 5,20, 0, 0,0,0,0, 0);
    tv[35] = mk(0,0,0, 5,20, 0, 0,0,0,0, 0);

    for (int i = 0; i < 36; i++) begin
      blank_time = tv[i].blank; off_time = tv[i].off;
      step(tv[i].en, tv[i].comp, tv[i].done);
      chk($sformatf("vec%0d", i), outs(), pack_exp(tv[i]));
    end

    // Constant over-current: three 1-cycle ON visits, then FAULT
    blank_time = 10'd2; off_time = 10'd3;
    run_chops(0, visits, long_v);
    chk("fault_visits", 32'(visits), 32'd3);
    chk("fault_long", 32'(long_v), 32'd0);
    chk("fault_outs", outs(), {13'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0});
    step(1'b1, 1'b0, 1'b1);
    chk("fault_hold", outs(), {13'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0});
    step(1'b0, 1'b0, 1'b0);
    chk("fault_clear", outs(), 32'd0);

    // Two early trips, one late trip, then three fresh early trips required
    run_chops(1, visits, long_v);
    chk("clear_visits", 32'(visits), 32'd6);
    chk("clear_long", 32'(long_v), 32'd1);
    chk("clear_fault", {31'd0, fault}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("clear_idle", outs(), 32'd0);

    // Async reset in ON: outputs drop without a clock edge
    begin
      bit hit = 0;
      for (int i = 0; i < 20; i++) begin
        step(1'b1, 1'b0, state == 3'd2);
        if (state == 3'd3) begin hit = 1; break; end
      end
      chk("reach_on", {31'd0, hit}, 32'd1);
    end
    chk("on_drive", {31'd0, phase_on}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset", outs(), 32'd0);
    @(negedge clk); reset = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", outs(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
